// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

   localparam int WORD_W         = 32;
   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      WRITE = 3'd2,
      CHECK = 3'd3,
      RUN   = 3'd4,
      ERROR = 3'd5
   } state_t;

   function automatic logic [BYTE_W-1:0] byte_of(input logic [WORD_W-1:0] w, input logic [1:0] idx);
      return w[idx*BYTE_W +: BYTE_W];
   endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Instruction word stream plus byte-wide instruction-memory write port.
interface imem_boot_loader_if #(
   parameter int ADDR_W = 8
);
   import imem_boot_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_data;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [BYTE_W-1:0] imem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata
   );

endinterface

// File: rtl/imem_boot_loader_word_byte_serializer.sv
// Holds one instruction word and presents it as four registered bytes, low byte first.
module word_byte_serializer
   import imem_boot_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WORD_W-1:0] word_in,
   input  logic              advance,
   output logic [BYTE_W-1:0] byte_out,
   output logic [1:0]        byte_idx
);

   logic [WORD_W-1:0] word_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_q   <= '0;
         byte_idx <= '0;
         byte_out <= '0;
      end else if (load) begin
         word_q   <= word_in;
         byte_idx <= 2'd0;
         byte_out <= byte_of(word_in, 2'd0);
      end else if (advance) begin
         byte_idx <= byte_idx + 2'd1;
         byte_out <= byte_of(word_q, byte_idx + 2'd1);
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams instruction words into byte-wide imem, holds the core in reset until loaded.
// Optional trailing XOR checksum word when IMEM_BOOT_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | after reset, core held in reset, waiting for start
// FETCH | in_ready high, waiting for the next word (data or checksum)
// WRITE | four byte writes of the latched word
// CHECK | compare received checksum against XOR of data words
// RUN   | program loaded, core released
// ERROR | checksum mismatch, core held in reset until start
module imem_boot_loader
   import imem_boot_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-2:0] word_cnt,
   imem_boot_loader_if.slave bus,
   output logic              core_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int                CNT_W = ADDR_W - 1;
   localparam logic [CNT_W-1:0]  CAP   = CNT_W'(2 ** (ADDR_W - 2));

   state_t            state, state_n;
   logic [CNT_W-1:0]  words_left;
   logic [CNT_W-1:0]  n_clamped;
   logic [ADDR_W-1:0] addr_q;
   logic              in_ready_q;
   logic              imem_we_q;
   logic [1:0]        byte_idx;
   logic [BYTE_W-1:0] byte_out;
   logic              accept;
   logic              is_data;
   logic              last_byte;
   logic              restart;
   logic              sum_ok;

   assign n_clamped = (word_cnt > CAP) ? CAP : word_cnt;
   assign accept    = (state == FETCH) && bus.in_valid && in_ready_q;
   assign last_byte = (state == WRITE) && (byte_idx == 2'(BYTES_PER_WORD - 1));
   assign restart   = start && ((state == IDLE) || (state == RUN) || (state == ERROR));

`ifdef IMEM_BOOT_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;

   logic [WORD_W-1:0] xor_acc;
   logic [WORD_W-1:0] sum_q;

   assign sum_ok = (sum_q == xor_acc);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         xor_acc <= '0;
         sum_q   <= '0;
         err     <= 1'b0;
      end else begin
         err <= (state_n == ERROR);
         if (restart)
            xor_acc <= '0;
         else if (accept && is_data)
            xor_acc <= xor_acc ^ bus.in_data;
         if (accept && !is_data)
            sum_q <= bus.in_data;
      end
   end
`else
   localparam bit CHK_EN = 1'b0;

   assign sum_ok = 1'b1;
   assign err    = 1'b0;
`endif

   // Once all data words are written, the only word left to fetch is the checksum.
   assign is_data = !(CHK_EN && (words_left == '0));

   always_comb begin
      state_n = state;
      case (state)
         IDLE, RUN, ERROR:
            if (start) state_n = ((n_clamped == '0) && !CHK_EN) ? RUN : FETCH;
         FETCH:
            if (accept) state_n = is_data ? WRITE : CHECK;
         WRITE:
            if (last_byte) state_n = ((words_left == CNT_W'(1)) && !CHK_EN) ? RUN : FETCH;
         CHECK:
            state_n = sum_ok ? RUN : ERROR;
         default:
            state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         words_left <= '0;
         addr_q     <= '0;
         in_ready_q <= 1'b0;
         imem_we_q  <= 1'b0;
         core_rst_n <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         in_ready_q <= (state_n == FETCH);
         imem_we_q  <= (state_n == WRITE);
         busy       <= (state_n == FETCH) || (state_n == WRITE) || (state_n == CHECK);
         done       <= (state_n == RUN);
         core_rst_n <= (state_n == RUN);
         if (restart) begin
            words_left <= n_clamped;
            addr_q     <= '0;
         end else begin
            if (last_byte)
               words_left <= words_left - CNT_W'(1);
            // addr_q always holds the address of the byte currently on the bus.
            if (state == WRITE)
               addr_q <= addr_q + ADDR_W'(1);
         end
      end
   end

   word_byte_serializer u_ser (
      .clk      (clk),
      .rst      (rst),
      .load     (accept && is_data),
      .word_in  (bus.in_data),
      .advance  ((state == WRITE) && !last_byte),
      .byte_out (byte_out),
      .byte_idx (byte_idx)
   );

   assign bus.in_ready   = in_ready_q;
   assign bus.imem_we    = imem_we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = byte_out;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader against a byte-stream reference model.
module tb_imem_boot_loader;

   localparam int ADDR_W = 8;
   localparam int CAP    = 2 ** (ADDR_W - 2);

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-2:0] word_cnt;
   logic              core_rst_n, busy, done, err;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int wr_a[$];
   int wr_d[$];
   int wr_c[$];
   logic [31:0] wq[$];
`ifdef IMEM_BOOT_CHECKSUM_EN
   bit bad_sum_g = 1'b0;
`endif

   imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .word_cnt   (word_cnt),
      .bus        (bus),
      .core_rst_n (core_rst_n),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.imem_we) begin
         wr_a.push_back(int'(bus.imem_addr));
         wr_d.push_back(int'(bus.imem_wdata));
         wr_c.push_back(cyc);
      end
   end

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic fill_random(input int n);
      wq = {};
      for (int i = 0; i < n; i++) wq.push_back($urandom);
   endtask

   // Called at a negedge; runs one load and checks the resulting byte stream and flags.
   task automatic do_load(input int cnt, input logic [31:0] w_in[$], input bit noise,
                          input bit mid_start, input int abort_addr);
      int n, idx, budget, start_cyc, run_cyc;
      bit sent_mid, aborted;
      logic [31:0] w[$];
      logic [31:0] x;
      n = (cnt > CAP) ? CAP : cnt;
      x = '0;
      w = {};
      for (int i = 0; i < n; i++) begin
         w.push_back(w_in[i]);
         x ^= w_in[i];
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      if (bad_sum_g) w.push_back((x == 32'd0) ? 32'd1 : 32'd0);
      else           w.push_back(x);
`endif
      wr_a.delete(); wr_d.delete(); wr_c.delete();
      start     = 1'b1;
      word_cnt  = (ADDR_W-1)'(cnt);
      start_cyc = cyc;
      @(negedge clk);
      start    = 1'b0;
      idx      = 0;
      budget   = 0;
      sent_mid = 1'b0;
      aborted  = 1'b0;
      run_cyc  = -1;
      while (budget < 4000) begin
         if (abort_addr >= 0 && bus.imem_we && int'(bus.imem_addr) == abort_addr) begin
            rst     = 1'b0;
            aborted = 1'b1;
            break;
         end
         if (idx >= w.size() && (core_rst_n || err)) begin
            run_cyc = cyc;
            break;
         end
         start = 1'b0;
         if (mid_start && !sent_mid && idx == 1 && !bus.in_ready) begin
            start    = 1'b1;
            word_cnt = (ADDR_W-1)'($urandom);
            sent_mid = 1'b1;
         end
         if (idx < w.size() && bus.in_ready && $urandom_range(0, 2) != 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w[idx];
            idx++;
         end else if (idx < w.size() && noise && !bus.in_ready) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w[idx];
         end else begin
            bus.in_valid = 1'b0;
            bus.in_data  = $urandom;
         end
         @(negedge clk);
         budget++;
      end
      bus.in_valid = 1'b0;
      start        = 1'b0;
      if (aborted) begin
         #1;
         chk_eq("abort_in_ready",   bus.in_ready,   0);
         chk_eq("abort_imem_we",    bus.imem_we,    0);
         chk_eq("abort_imem_addr",  bus.imem_addr,  0);
         chk_eq("abort_imem_wdata", bus.imem_wdata, 0);
         chk_eq("abort_core_rst_n", core_rst_n,     0);
         chk_eq("abort_busy",       busy,           0);
         chk_eq("abort_done",       done,           0);
         return;
      end
      chk_eq("load_finished", run_cyc >= 0, 1);
      repeat (3) @(negedge clk);
      chk_eq($sformatf("wr_count n=%0d", n), wr_a.size(), 4 * n);
      for (int i = 0; i < wr_a.size() && i < 4 * n; i++) begin
         chk_eq($sformatf("wr_addr[%0d]", i), wr_a[i], i);
         chk_eq($sformatf("wr_data[%0d]", i), wr_d[i], (w[i/4] >> (8 * (i % 4))) & 32'hff);
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      if (bad_sum_g) begin
         chk_eq("bad_sum_err",        err,        1);
         chk_eq("bad_sum_done",       done,       0);
         chk_eq("bad_sum_core_rst_n", core_rst_n, 0);
         chk_eq("bad_sum_busy",       busy,       0);
         return;
      end
`else
      if (n == 0)
         chk_eq("run_timing_empty", run_cyc, start_cyc + 1);
      else if (wr_c.size() > 0)
         chk_eq("run_timing", run_cyc, wr_c[wr_c.size()-1] + 1);
`endif
      chk_eq("done",       done,       1);
      chk_eq("busy",       busy,       0);
      chk_eq("core_rst_n", core_rst_n, 1);
      chk_eq("err",        err,        0);
   endtask

   initial begin
      int quiet;
      rst          = 1'b0;
      start        = 1'b0;
      word_cnt     = '0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (2) @(negedge clk);
      chk_eq("rst_in_ready",   bus.in_ready,   0);
      chk_eq("rst_imem_we",    bus.imem_we,    0);
      chk_eq("rst_imem_addr",  bus.imem_addr,  0);
      chk_eq("rst_imem_wdata", bus.imem_wdata, 0);
      chk_eq("rst_core_rst_n", core_rst_n,     0);
      chk_eq("rst_busy",       busy,           0);
      chk_eq("rst_done",       done,           0);
      chk_eq("rst_err",        err,            0);
      rst   = 1'b1;
      quiet = 0;
      repeat (20) begin
         @(negedge clk);
         if (core_rst_n || bus.in_ready || bus.imem_we || busy || done) quiet++;
      end
      chk_eq("idle_quiet", quiet, 0);

      wq = {32'h00100093, 32'h00208433};
      do_load(2, wq, 1'b0, 1'b0, -1);

      wq = {};
      do_load(0, wq, 1'b0, 1'b0, -1);

      fill_random(5);
      do_load(5, wq, 1'b1, 1'b1, -1);

      fill_random(3);
      do_load(3, wq, 1'b0, 1'b0, 6);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      fill_random(2);
      do_load(2, wq, 1'b0, 1'b0, -1);

      fill_random(100);
      do_load(100, wq, 1'b1, 1'b0, -1);

      for (int r = 0; r < 6; r++) begin
         int c;
         c = $urandom_range(0, 2 * CAP - 1);
         fill_random(c);
         do_load(c, wq, 1'($urandom), 1'($urandom), -1);
      end

`ifdef IMEM_BOOT_CHECKSUM_EN
      wq = {32'h00007033, 32'h00100093};
      bad_sum_g = 1'b0;
      do_load(2, wq, 1'b0, 1'b0, -1);
      bad_sum_g = 1'b1;
      do_load(2, wq, 1'b0, 1'b0, -1);
      wq = {};
      bad_sum_g = 1'b0;
      do_load(0, wq, 1'b0, 1'b0, -1);
      for (int r = 0; r < 4; r++) begin
         int c;
         c = $urandom_range(0, 12);
         fill_random(c);
         bad_sum_g = 1'($urandom);
         do_load(c, wq, 1'b1, 1'b0, -1);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
